adc_spi_emulator: RTL and testbench

Synthesizable responder for the ADC serial interface: the far end of the ADC read controller. It watches the active-low convert strobe and serial clock driven by the controller, performs a timed dummy conversion, and shifts a 16-bit sample out MSB-first on MISO. It also returns an echo of the serial clock for the controller's `adc_sck_i` input. It sits in the FPGA loopback/test build in place of the physical ADC, so the read path can be verified end-to-end without silicon.

---
 rtl/adc_spi_emulator.sv | 196 +++++++++++++++++++
 tb/tb_adc_spi_emulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : adc_spi_emulator
//  Purpose  : Stand-in for the serial ADC. Performs a timed dummy conversion
//             on a convert strobe and shifts a pattern sample out MSB-first.
//  Revision : 1.0  initial release
// ============================================================================
module adc_spi_emulator #(
    parameter int               DATA_W        = 16,
    parameter int               CONV_CYCLES   = 40,
    parameter int               ECHO_DLY      = 2,
    parameter logic [DATA_W-1:0] FIXED_PATTERN = 16'hA5C3
) (
    input  logic              clk_adc,
    input  logic              rst_n,
    input  logic              adc_cnv_n_i,
    input  logic              adc_sck_i,
    input  logic [1:0]        pattern_sel_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic              adc_miso_o,
    output logic              adc_sck_echo_o,
    output logic              busy_o,
    output logic [15:0]       conv_count_o,
    output logic [1:0]        err_o
);

    localparam int                c_bits_w = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] c_alt_a  = {(DATA_W/2){2'b10}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_cnv_sync, r_sck_sync;
    logic [7:0]          r_conv_cnt;
    logic [c_bits_w-1:0] r_bits;
    logic [DATA_W-1:0]   r_shift, r_ramp, r_alt, w_sample;
    logic                r_miso, r_busy;
    logic [15:0]         r_conv_count;
    logic [1:0]          r_err;
    logic                w_echo;
    logic                w_cnv_fall, w_cnv_rise, w_sck_fall, w_sck_rise;
    logic                w_latch, w_load_msb, w_shift, w_done, w_abort, w_sck_err, w_busy_nxt;

    // Stages 0/1 synchronize, stage 2 holds the previous value for edge detection
    always_ff @(posedge clk_adc or negedge rst_n) begin
        if (!rst_n) begin
            r_cnv_sync <= 3'b111;
            r_sck_sync <= 3'b000;
        end else begin
            r_cnv_sync <= {r_cnv_sync[1:0], adc_cnv_n_i};
            r_sck_sync <= {r_sck_sync[1:0], adc_sck_i};
        end
    end

    assign w_cnv_fall =  r_cnv_sync[2] & ~r_cnv_sync[1];
    assign w_cnv_rise = ~r_cnv_sync[2] &  r_cnv_sync[1];
    assign w_sck_fall =  r_sck_sync[2] & ~r_sck_sync[1];
    assign w_sck_rise = ~r_sck_sync[2] &  r_sck_sync[1];

    always_comb begin
        w_sample = r_ramp;
        case (pattern_sel_i)
            2'd1:    w_sample = FIXED_PATTERN;
            2'd2:    w_sample = r_alt;
            2'd3:    w_sample = sample_i;
            default: w_sample = r_ramp;
        endcase
    end

    always_ff @(posedge clk_adc or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_load_msb  = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_sck_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cnv_fall) begin
                    w_state_nxt = S_CONV;
                    w_latch     = 1'b1;
                end
            end
            S_CONV: begin
                if (w_cnv_rise) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_sck_err = w_sck_rise | w_sck_fall;
                    if (r_conv_cnt == 8'd0) begin
                        w_state_nxt = S_SHIFT;
                        w_load_msb  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (w_cnv_rise) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sck_fall) begin
                    if (r_bits == c_bits_w'(DATA_W)) begin
                        w_state_nxt = S_DONE;
                        w_done      = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (w_cnv_rise) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_CONV) || (w_state_nxt == S_SHIFT);
    end

    always_ff @(posedge clk_adc or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_cnt   <= 8'd0;
            r_bits       <= '0;
            r_shift      <= '0;
            r_ramp       <= '0;
            r_alt        <= c_alt_a;
            r_miso       <= 1'b0;
            r_busy       <= 1'b0;
            r_conv_count <= 16'd0;
            r_err        <= 2'b00;
        end else begin
            r_busy <= w_busy_nxt;
            // Both generators advance on every latch, whichever mode is selected
            if (w_latch) begin
                r_shift    <= w_sample;
                r_ramp     <= r_ramp + DATA_W'(1);
                r_alt      <= ~r_alt;
                r_conv_cnt <= 8'(CONV_CYCLES - 1);
                r_bits     <= '0;
            end else if (r_state == S_CONV && r_conv_cnt != 8'd0) begin
                r_conv_cnt <= r_conv_cnt - 8'd1;
            end
            if (r_state == S_SHIFT && w_sck_rise && r_bits != c_bits_w'(DATA_W))
                r_bits <= r_bits + c_bits_w'(1);
            if (w_load_msb)
                r_miso <= r_shift[DATA_W-1];
            if (w_shift) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_miso  <= r_shift[DATA_W-2];
            end
            if (w_done) begin
                r_miso       <= 1'b0;
                r_conv_count <= r_conv_count + 16'd1;
            end
            if (w_abort) begin
                r_miso <= 1'b0;
                if (r_state == S_SHIFT) r_err[1] <= 1'b1;
            end
            if (w_sck_err) r_err[0] <= 1'b1;
        end
    end

    generate
        if (ECHO_DLY == 0) begin : g_echo_direct
            assign w_echo = r_sck_sync[2];
        end else begin : g_echo_pipe
            logic [ECHO_DLY-1:0] r_echo_pipe;
            always_ff @(posedge clk_adc or negedge rst_n) begin
                if (!rst_n) begin
                    r_echo_pipe <= '0;
                end else begin
                    r_echo_pipe[0] <= r_sck_sync[2];
                    for (int i = 1; i < ECHO_DLY; i++)
                        r_echo_pipe[i] <= r_echo_pipe[i-1];
                end
            end
            assign w_echo = r_echo_pipe[ECHO_DLY-1];
        end
    endgenerate

    assign adc_miso_o     = r_miso;
    assign adc_sck_echo_o = w_echo;
    assign busy_o         = r_busy;
    assign conv_count_o   = r_conv_count;
    assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_spi_emulator
//  Purpose  : Self-checking bench: directed table plus randomized transfers
//             against a counting reference model of the ADC emulator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_spi_emulator;

    localparam int CONV_CYCLES = 40;
    localparam int ECHO_DLY    = 2;
    localparam int LAG_NOM     = 3 + ECHO_DLY;

    logic        clk_adc = 1'b0;
    logic        rst_n = 1'b0;
    logic        adc_cnv_n_i = 1'b1;
    logic        adc_sck_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic [15:0] sample_i = 16'd0;
    logic        adc_miso_o, adc_sck_echo_o, busy_o;
    logic [15:0] conv_count_o;
    logic [1:0]  err_o;

    adc_spi_emulator #(
        .DATA_W(16), .CONV_CYCLES(CONV_CYCLES), .ECHO_DLY(ECHO_DLY), .FIXED_PATTERN(16'hA5C3)
    ) dut (
        .clk_adc(clk_adc), .rst_n(rst_n), .adc_cnv_n_i(adc_cnv_n_i), .adc_sck_i(adc_sck_i),
        .pattern_sel_i(pattern_sel_i), .sample_i(sample_i), .adc_miso_o(adc_miso_o),
        .adc_sck_echo_o(adc_sck_echo_o), .busy_o(busy_o), .conv_count_o(conv_count_o),
        .err_o(err_o)
    );

    always #5 clk_adc = ~clk_adc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Echo monitor: each pin edge of SCK must reappear on the echo 4..6 cycles later
    int          cyc = 0;
    int          sck_edges[$];
    logic        prev_sck = 1'b0, prev_echo = 1'b0;
    always @(negedge clk_adc) begin
        cyc++;
        if (!rst_n) begin
            sck_edges.delete();
        end else begin
            if (adc_sck_i != prev_sck) sck_edges.push_back(cyc);
            if (adc_sck_echo_o != prev_echo) begin
                n_checks++;
                if (sck_edges.size() == 0) begin
                    n_errors++;
                    $display("FAIL echo_lag: echo edge at cycle %0d with no pending sck edge", cyc);
                end else begin
                    int lag;
                    lag = cyc - sck_edges.pop_front();
                    if (lag < LAG_NOM - 1 || lag > LAG_NOM + 1) begin
                        n_errors++;
                        $display("FAIL echo_lag: got %0d cycles, want %0d..%0d", lag, LAG_NOM-1, LAG_NOM+1);
                    end
                end
            end
        end
        prev_sck  = adc_sck_i;
        prev_echo = adc_sck_echo_o;
    end

    // Reference model: everything derived from how many samples have been latched
    int          m_latches;
    logic [15:0] m_count;
    logic [1:0]  m_err;

    task automatic model_reset();
        m_latches = 0;
        m_count   = 16'd0;
        m_err     = 2'b00;
    endtask

    task automatic model_xfer(input logic [1:0] mode, input logic [15:0] ext, input int nbits,
                              input bit early, output logic [15:0] exp_data);
        case (mode)
            2'd0:    exp_data = 16'(m_latches);
            2'd1:    exp_data = 16'hA5C3;
            2'd2:    exp_data = (m_latches % 2 == 0) ? 16'hAAAA : 16'h5555;
            default: exp_data = ext;
        endcase
        m_latches++;
        if (early) m_err[0] = 1'b1;
        if (nbits < 16) m_err[1] = 1'b1;
        else m_count = m_count + 16'd1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_adc);
        #2;
    endtask

    task automatic run_xfer(input logic [1:0] mode, input logic [15:0] ext, input int nbits,
                            input bit early, input int hp, input logic [15:0] exp_data,
                            input logic [15:0] exp_cnt, input logic [1:0] exp_err);
        logic [15:0] got;
        logic [15:0] want;
        got = 16'd0;
        pattern_sel_i = mode;
        sample_i      = ext;
        cycles(2);
        adc_cnv_n_i = 1'b0;
        if (early) begin
            cycles(8);
            adc_sck_i = 1'b1;
            cycles(5);
            adc_sck_i = 1'b0;
            cycles(CONV_CYCLES);
        end else begin
            cycles(CONV_CYCLES + 8);
        end
        @(negedge clk_adc);
        check("busy_in_xfer", {31'd0, busy_o}, 32'd1);
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk_adc);
            got = {got[14:0], adc_miso_o};
            cycles(1);
            adc_sck_i = 1'b1;
            if (b == 0) sample_i = 16'hFFFF;
            cycles(hp);
            adc_sck_i = 1'b0;
            cycles(hp - 1);
        end
        cycles(4);
        if (nbits < 16) begin
            adc_cnv_n_i = 1'b1;
            cycles(6);
        end
        @(negedge clk_adc);
        want = exp_data >> (16 - nbits);
        check("data", {16'd0, got}, {16'd0, want});
        check("miso_after", {31'd0, adc_miso_o}, 32'd0);
        check("busy_after", {31'd0, busy_o}, 32'd0);
        check("conv_count", {16'd0, conv_count_o}, {16'd0, exp_cnt});
        check("err", {30'd0, err_o}, {30'd0, exp_err});
        if (nbits == 16) begin
            cycles(1);
            adc_cnv_n_i = 1'b1;
            cycles(6);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] ext;
        int          nbits;
        bit          early;
        logic [15:0] exp_data;
        logic [15:0] exp_cnt;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [15:0] mexp;

        tbl[0] = '{2'd0, 16'h0000, 16, 1'b0, 16'h0000, 16'd1, 2'b00};
        tbl[1] = '{2'd0, 16'h0000, 16, 1'b0, 16'h0001, 16'd2, 2'b00};
        tbl[2] = '{2'd0, 16'h0000, 16, 1'b0, 16'h0002, 16'd3, 2'b00};
        tbl[3] = '{2'd1, 16'h0000, 16, 1'b0, 16'hA5C3, 16'd4, 2'b00};
        tbl[4] = '{2'd2, 16'h0000, 16, 1'b0, 16'hAAAA, 16'd5, 2'b00};
        tbl[5] = '{2'd2, 16'h0000, 16, 1'b0, 16'h5555, 16'd6, 2'b00};
        tbl[6] = '{2'd3, 16'h1234, 16, 1'b0, 16'h1234, 16'd7, 2'b00};
        tbl[7] = '{2'd1, 16'h0000, 16, 1'b1, 16'hA5C3, 16'd8, 2'b01};
        tbl[8] = '{2'd0, 16'h0000,  7, 1'b0, 16'h0008, 16'd8, 2'b11};
        tbl[9] = '{2'd0, 16'h0000, 16, 1'b0, 16'h0009, 16'd9, 2'b11};

        model_reset();
        cycles(4);
        check("rst_miso",  {31'd0, adc_miso_o}, 32'd0);
        check("rst_echo",  {31'd0, adc_sck_echo_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_count", {16'd0, conv_count_o}, 32'd0);
        check("rst_err",   {30'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        cycles(4);

        for (int i = 0; i < 10; i++) begin
            model_xfer(tbl[i].mode, tbl[i].ext, tbl[i].nbits, tbl[i].early, mexp);
            run_xfer(tbl[i].mode, tbl[i].ext, tbl[i].nbits, tbl[i].early, 8,
                     tbl[i].exp_data, tbl[i].exp_cnt, tbl[i].exp_err);
        end

        for (int i = 0; i < 12; i++) begin
            logic [1:0]  mode;
            logic [15:0] ext;
            int          nbits, hp;
            bit          early;
            mode  = 2'($urandom_range(0, 3));
            ext   = 16'($urandom);
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            early = ($urandom_range(0, 4) == 0);
            hp    = $urandom_range(5, 9);
            model_xfer(mode, ext, nbits, early, mexp);
            run_xfer(mode, ext, nbits, early, hp, mexp, m_count, m_err);
        end

        // Reset in the middle of shifting: outputs clear without a clock edge
        pattern_sel_i = 2'd0;
        cycles(2);
        adc_cnv_n_i = 1'b0;
        cycles(CONV_CYCLES + 8);
        for (int b = 0; b < 5; b++) begin
            adc_sck_i = 1'b1;
            cycles(8);
            adc_sck_i = 1'b0;
            cycles(8);
        end
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_miso",  {31'd0, adc_miso_o}, 32'd0);
        check("midrst_echo",  {31'd0, adc_sck_echo_o}, 32'd0);
        check("midrst_busy",  {31'd0, busy_o}, 32'd0);
        check("midrst_count", {16'd0, conv_count_o}, 32'd0);
        check("midrst_err",   {30'd0, err_o}, 32'd0);
        adc_cnv_n_i = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        model_reset();
        model_xfer(2'd0, 16'h0000, 16, 1'b0, mexp);
        run_xfer(2'd0, 16'h0000, 16, 1'b0, 8, 16'h0000, 16'd1, 2'b00);
        model_xfer(2'd2, 16'h0000, 16, 1'b0, mexp);
        run_xfer(2'd2, 16'h0000, 16, 1'b0, 6, mexp, m_count, m_err);

        cycles(10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
